seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. It holds a 32-bit word from the CPU debug path, such as the PC or a selected register. One digit at a time, it presents the 4-bit nibble to the downstream hex-to-7-segment decoder and drives the matching active-low anode. New words are accepted through a request/acknowledge handshake. They are applied only at frame boundaries, so the display never shows a mix of old and new digits.

---
 rtl/seg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Holds a 32-bit word and swaps in newly captured words only at frame boundaries.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        load_req,
    output logic        load_ack,
    input  logic        lz_blank,
    input  logic [7:0]  dp_mask,
    output logic [3:0]  hex,
    output logic [7:0]  an,
    output logic        dp_n
);
    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] GUARD_T  = TW'(GUARD);

    // Bit i set when digit i (i > 0) and every digit above it hold zero.
    function automatic logic [7:0] blank_mask(input logic [31:0] word, input logic en);
        logic [7:0] m;
        logic       zero_above;
        m          = 8'h00;
        zero_above = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_above = zero_above && (word[4*i +: 4] == 4'h0);
            m[i]       = en && zero_above;
        end
        return m;
    endfunction

    logic [TW-1:0] r_tick;
    logic [2:0]    r_digit;
    logic [31:0]   r_active;
    logic [31:0]   r_shadow;
    logic          r_pending;
    logic          r_ack;
    logic [3:0]    r_hex;
    logic [7:0]    r_an;
    logic          r_dp_n;

    logic          w_tick_wrap;
    logic          w_frame_end;
    logic [TW-1:0] w_tick_nxt;
    logic [2:0]    w_digit_nxt;
    logic [31:0]   w_active_nxt;
    logic [31:0]   w_shadow_nxt;
    logic          w_pending_nxt;
    logic          w_ack_nxt;
    logic [7:0]    w_blank;
    logic          w_slot_blank;
    logic          w_guard;
    logic [3:0]    w_hex_nxt;
    logic [7:0]    w_an_nxt;
    logic          w_dp_n_nxt;

    // Scan counters and the load handshake; a request on frame_end bypasses the shadow.
    always_comb begin
        w_tick_wrap   = (r_tick == TICK_MAX);
        w_frame_end   = w_tick_wrap && (r_digit == 3'd7);
        w_active_nxt  = r_active;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        w_ack_nxt     = 1'b0;
        if (w_tick_wrap) begin
            w_tick_nxt  = {TW{1'b0}};
            w_digit_nxt = r_digit + 3'd1;
        end else begin
            w_tick_nxt  = r_tick + TW'(1);
            w_digit_nxt = r_digit;
        end
        if (w_frame_end) begin
            if (load_req) begin
                w_active_nxt = data_in;
            end else if (r_pending) begin
                w_active_nxt = r_shadow;
            end else begin
                w_active_nxt = r_active;
            end
            w_pending_nxt = 1'b0;
            w_ack_nxt     = load_req | r_pending;
        end else if (load_req) begin
            w_shadow_nxt  = data_in;
            w_pending_nxt = 1'b1;
        end else begin
            w_shadow_nxt  = r_shadow;
            w_pending_nxt = r_pending;
        end
    end

    // Display outputs for the slot the counters are about to enter.
    always_comb begin
        w_blank      = blank_mask(w_active_nxt, lz_blank);
        w_slot_blank = w_blank[w_digit_nxt];
        w_guard      = (w_tick_nxt < GUARD_T);
        w_hex_nxt    = w_active_nxt[{w_digit_nxt, 2'b00} +: 4];
        if (w_guard || w_slot_blank) begin
            w_an_nxt   = 8'hFF;
            w_dp_n_nxt = 1'b1;
        end else begin
            w_an_nxt   = ~(8'h01 << w_digit_nxt);
            w_dp_n_nxt = ~dp_mask[w_digit_nxt];
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick    <= {TW{1'b0}};
            r_digit   <= 3'd0;
            r_active  <= 32'h0000_0000;
            r_shadow  <= 32'h0000_0000;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
            r_hex     <= 4'h0;
            r_an      <= 8'hFF;
            r_dp_n    <= 1'b1;
        end else begin
            r_tick    <= w_tick_nxt;
            r_digit   <= w_digit_nxt;
            r_active  <= w_active_nxt;
            r_shadow  <= w_shadow_nxt;
            r_pending <= w_pending_nxt;
            r_ack     <= w_ack_nxt;
            r_hex     <= w_hex_nxt;
            r_an      <= w_an_nxt;
            r_dp_n    <= w_dp_n_nxt;
        end
    end

    assign load_ack = r_ack;
    assign hex      = r_hex;
    assign an       = r_an;
    assign dp_n     = r_dp_n;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed and random checks of seg_scan_ctrl (SCAN_DIV = 8, GUARD = 2) against a
// frame-position reference model.
module tb_seg_scan_ctrl;
    localparam int SD = 8;
    localparam int GD = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        load_req;
    logic        load_ack;
    logic        lz_blank;
    logic [7:0]  dp_mask;
    logic [3:0]  hex;
    logic [7:0]  an;
    logic        dp_n;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the 8*SD-cycle frame plus the displayed word.
    int          m_p;
    logic [31:0] m_disp;
    logic [31:0] m_shadow;
    logic        m_pend;
    logic        m_ack;
    int          ack_count;

    seg_scan_ctrl #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_req(load_req),
        .load_ack(load_ack), .lz_blank(lz_blank), .dp_mask(dp_mask),
        .hex(hex), .an(an), .dp_n(dp_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_p = 0; m_disp = 32'h0; m_shadow = 32'h0; m_pend = 1'b0; m_ack = 1'b0;
    endtask

    task automatic compare_outputs();
        int          tick;
        int          dig;
        logic [31:0] upper;
        logic        blank;
        logic [7:0]  one;
        logic [7:0]  e_an;
        logic        e_dp;
        tick  = m_p % SD;
        dig   = m_p / SD;
        upper = m_disp >> (4 * dig);
        blank = lz_blank && (dig != 0) && (upper == 32'h0);
        one   = 8'h01;
        if (tick < GD || blank) begin
            e_an = 8'hFF;
            e_dp = 1'b1;
        end else begin
            e_an = ~(one << dig);
            e_dp = ~dp_mask[dig];
        end
        chk("hex", {28'h0, hex}, upper & 32'hF);
        chk("an", {24'h0, an}, {24'h0, e_an});
        chk("dp_n", {31'h0, dp_n}, {31'h0, e_dp});
        chk("load_ack", {31'h0, load_ack}, {31'h0, m_ack});
    endtask

    // One clock with the given request, then model update and comparison.
    task automatic cycle(input logic req, input logic [31:0] data);
        load_req = req;
        data_in  = data;
        @(posedge clk);
        if (m_p == 8 * SD - 1) begin
            if (req) m_disp = data;
            else if (m_pend) m_disp = m_shadow;
            m_ack  = req | m_pend;
            m_pend = 1'b0;
        end else begin
            m_ack = 1'b0;
            if (req) begin
                m_shadow = data;
                m_pend   = 1'b1;
            end
        end
        m_p = (m_p + 1) % (8 * SD);
        #1;
        compare_outputs();
        if (load_ack === 1'b1) ack_count++;
        load_req = 1'b0;
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < 8 * SD && m_p != pos; k++) cycle(1'b0, 32'h0);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b1; load_req = 1'b0; data_in = 32'h0; lz_blank = 1'b0; dp_mask = 8'h00;
        ack_count = 0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        compare_outputs();

        // Plain scan of one frame plus a bit, no load.
        run(70);
        chk("no_ack_idle", ack_count, 0);

        // Load mid-frame at digit 3.
        run_to(3 * SD);
        cycle(1'b1, 32'h1234_5678);
        run(8 * SD + 8);

        // Two loads in one frame; only the second is shown, one ack.
        ack_count = 0;
        run_to(10);
        cycle(1'b1, 32'hAAAA_AAAA);
        run_to(40);
        cycle(1'b1, 32'h0000_BEEF);
        run(8 * SD);
        chk("two_loads_acks", ack_count, 1);

        // A load pending, then a load on the frame_end cycle itself.
        run_to(20);
        cycle(1'b1, 32'h1111_1111);
        run_to(8 * SD - 1);
        cycle(1'b1, 32'hCAFE_F00D);
        run(8 * SD);

        // Leading-zero blanking with a decimal point on digit 1.
        lz_blank = 1'b1;
        dp_mask  = 8'h02;
        run_to(30);
        cycle(1'b1, 32'h0000_0A00);
        run(2 * 8 * SD);

        // Randomized loads, masks and blanking.
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] d;
            if ((k % 50) == 0) begin
                lz_blank = 1'($urandom_range(0, 1));
                dp_mask  = 8'($urandom);
            end
            d = $urandom;
            d = d >> ($urandom_range(0, 8) * 4);
            cycle(($urandom_range(0, 15) == 0), d);
        end

        // Asynchronous reset mid-slot with a word pending.
        run_to(2 * SD + 1);
        cycle(1'b1, 32'h9876_5432);
        run(3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_an", {24'h0, an}, 32'hFF);
        chk("rst_dp_n", {31'h0, dp_n}, 32'h1);
        chk("rst_ack", {31'h0, load_ack}, 32'h0);
        chk("rst_hex", {28'h0, hex}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare_outputs();
        run(8 * SD + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
